// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table: 2-bit counter encodings
// and the saturating train step used by every table entry.
package bht_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] BHT_RESET_STATE = WNT;

    // Move one step toward the observed direction, sticking at either end.
    function automatic logic [1:0] sat2_next(input logic [1:0] state, input logic taken);
        logic [1:0] result;
        result = state;
        if (taken) begin
            if (state != ST) result = state + 2'b01;
        end else begin
            if (state != SNT) result = state - 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/bht_predictor.sv
// Branch history table: 2^IDX_W saturating 2-bit counters indexed by word PC,
// one-cycle registered prediction, same-cycle training, mispredict counter.
module bht_predictor
    import bht_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            query_valid,
    input  logic [PC_W-1:0] query_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_mispredict,
    output logic [31:0]     mispredict_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       bht_q [DEPTH];
    logic [IDX_W-1:0] q_idx;
    logic [IDX_W-1:0] u_idx;

    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [PC_W-1:0]  pred_pc_q, pred_pc_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [1:0]       upd_state_d;

    assign q_idx = query_pc[IDX_W+1:2];
    assign u_idx = upd_pc[IDX_W+1:2];

    // The prediction reads the pre-update entry; there is deliberately no bypass.
    always_comb begin
        pred_valid_d = query_valid;
        pred_taken_d = query_valid & bht_q[q_idx][1];
        pred_pc_d    = query_pc;
        cnt_d        = cnt_q + 32'(upd_valid & upd_mispredict);
        upd_state_d  = sat2_next(bht_q[u_idx], upd_taken);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= BHT_RESET_STATE;
            end
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
            cnt_q        <= '0;
        end else if (enable) begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_pc_q    <= pred_pc_d;
            cnt_q        <= cnt_d;
            if (upd_valid) begin
                bht_q[u_idx] <= upd_state_d;
            end
        end
    end

    assign pred_valid     = pred_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_pc        = pred_pc_q;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed plus random stimulus for bht_predictor; expected outputs come from
// a behavioural counter-table model and flow through a scoreboard queue.
module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        query_valid;
    logic [31:0] query_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [31:0] mispredict_cnt;

    always #5 clk = ~clk;

    bht_predictor #(.IDX_W(8), .PC_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .query_valid    (query_valid),
        .query_pc       (query_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    typedef struct {
        logic        v;
        logic        t;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        exp_prev;
    logic [1:0]  model_tbl [256];
    logic [31:0] model_cnt;
    int          errors = 0;
    int          checks = 0;
    int          cycle  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, expv);
        end
    endtask

    // Drive one cycle; model predicts outputs, scoreboard compares after the edge.
    task automatic step(input logic rst, input logic en,
                        input logic qv, input logic [31:0] qpc,
                        input logic uv, input logic [31:0] upc,
                        input logic ut, input logic um);
        exp_t e;
        exp_t got;
        logic [1:0] cur;
        @(negedge clk);
        reset = rst; enable = en;
        query_valid = qv; query_pc = qpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_mispredict = um;
        if (rst) begin
            for (int i = 0; i < 256; i++) model_tbl[i] = 2'b01;
            model_cnt = 0;
            e = '{v: 1'b0, t: 1'b0, pc: 32'h0, cnt: 32'h0};
        end else if (en) begin
            e.v  = qv;
            e.t  = qv & model_tbl[qpc[9:2]][1];
            e.pc = qpc;
            if (uv) begin
                cur = model_tbl[upc[9:2]];
                if (ut) model_tbl[upc[9:2]] = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
                else    model_tbl[upc[9:2]] = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
                if (um) model_cnt = model_cnt + 1;
            end
            e.cnt = model_cnt;
        end else begin
            e = exp_prev;
        end
        sb.push_back(e);
        exp_prev = e;
        @(posedge clk);
        #1;
        cycle++;
        got = sb.pop_front();
        check("pred_valid", {31'b0, pred_valid}, {31'b0, got.v});
        check("pred_taken", {31'b0, pred_taken}, {31'b0, got.t});
        check("pred_pc", pred_pc, got.pc);
        check("mispredict_cnt", mispredict_cnt, got.cnt);
        $display("cyc=%0d rst=%0b en=%0b q=%0b@%h u=%0b@%h t=%0b m=%0b -> pv=%0b pt=%0b pc=%h cnt=%0d",
                 cycle, rst, en, qv, qpc, uv, upc, ut, um, pred_valid, pred_taken, pred_pc, mispredict_cnt);
    endtask

    task automatic query(input logic [31:0] pc);
        step(1'b0, 1'b1, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic train(input logic [31:0] pc, input logic t, input logic m);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, pc, t, m);
    endtask

    initial begin
        logic [31:0] cnt_before;
        logic [1:0]  entry_before;
        reset = 1'b1; enable = 1'b0;
        query_valid = 1'b0; query_pc = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_mispredict = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("reset_entry0", {30'b0, dut.bht_q[0]}, 32'h1);
        check("reset_cnt", mispredict_cnt, 32'h0);

        // First query after reset: weak not-taken
        query(32'h0000_0000);
        check("q0_valid", {31'b0, pred_valid}, 32'h1);
        check("q0_taken", {31'b0, pred_taken}, 32'h0);

        // Train 0x100 up and through saturation, then back down
        train(32'h100, 1'b1, 1'b0);
        train(32'h100, 1'b1, 1'b0);
        query(32'h100);
        check("q100_taken", {31'b0, pred_taken}, 32'h1);
        check("e100_st", {30'b0, dut.bht_q[8'h40]}, 32'h3);
        train(32'h100, 1'b1, 1'b0);
        train(32'h100, 1'b1, 1'b0);
        check("e100_sat_hi", {30'b0, dut.bht_q[8'h40]}, 32'h3);
        train(32'h100, 1'b0, 1'b1);
        train(32'h100, 1'b0, 1'b1);
        train(32'h100, 1'b0, 1'b1);
        check("e100_snt", {30'b0, dut.bht_q[8'h40]}, 32'h0);
        train(32'h100, 1'b0, 1'b0);
        check("e100_sat_lo", {30'b0, dut.bht_q[8'h40]}, 32'h0);
        query(32'h100);
        check("q100_nt", {31'b0, pred_taken}, 32'h0);

        // Same-cycle query and update: no bypass
        step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0);
        check("same_cycle_old", {31'b0, pred_taken}, 32'h0);
        query(32'h40);
        check("next_cycle_new", {31'b0, pred_taken}, 32'h1);

        // Aliasing: 0x004 and 0x404 share index 1
        train(32'h004, 1'b1, 1'b0);
        query(32'h404);
        check("alias_taken", {31'b0, pred_taken}, 32'h1);

        // Stall with requests present
        cnt_before   = mispredict_cnt;
        entry_before = dut.bht_q[1];
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h004, 1'b0, 1'b1);
        check("stall_cnt", mispredict_cnt, cnt_before);
        check("stall_entry", {30'b0, dut.bht_q[1]}, {30'b0, entry_before});
        check("stall_pv", {31'b0, pred_valid}, 32'h1);
        check("stall_pc", pred_pc, 32'h404);
        train(32'h004, 1'b0, 1'b1);
        check("post_stall_cnt", mispredict_cnt, cnt_before + 32'd1);

        // Mid-stream reset: train 0x100 to strong taken, count five mispredicts
        for (int i = 0; i < 3; i++) train(32'h100, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) train(32'h200, 1'b1, 1'b1);
        check("pre_rst_e100", {30'b0, dut.bht_q[8'h40]}, 32'h3);
        step(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1);
        check("rst_cnt", mispredict_cnt, 32'h0);
        check("rst_drop_upd", {30'b0, dut.bht_q[8'h40]}, 32'h1);
        query(32'h100);
        check("rst_q100", {31'b0, pred_taken}, 32'h0);

        // Random traffic over a small set of indices to exercise collisions
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                 1'($urandom), {$urandom_range(0, 3) == 0 ? $urandom : 32'h0} + {26'b0, 4'($urandom), 2'($urandom)},
                 1'($urandom), {$urandom_range(0, 3) == 0 ? $urandom : 32'h0} + {26'b0, 4'($urandom), 2'($urandom)},
                 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
